// File: rtl/alu_writeback.sv
// Writeback stage behind the 16-bit ALU: one-entry stage register feeding the
// register-file write port, plus condition codes, branch resolution and a retire counter.
module alu_writeback #(
    parameter int W  = 16,
    parameter int RA = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic          ex_is_br,
    input  logic [3:0]    ex_opcode,
    input  logic [RA-1:0] ex_rd,
    input  logic [W-1:0]  ex_result,
    input  logic          ex_s,
    input  logic          ex_z,
    input  logic          ex_c,
    input  logic          ex_v,
    input  logic [2:0]    ex_cond,
    input  logic [W-1:0]  ex_target,
    output logic          rf_we,
    output logic [RA-1:0] rf_waddr,
    output logic [W-1:0]  rf_wdata,
    input  logic          rf_ready,
    output logic          fwd_valid,
    output logic [RA-1:0] fwd_rd,
    output logic [W-1:0]  fwd_data,
    output logic [3:0]    flags,
    output logic          br_taken,
    output logic [W-1:0]  br_target,
    output logic [15:0]   retired
);

    logic          valid_q;
    logic          we_q;
    logic          is_br_q;
    logic          taken_q;
    logic [RA-1:0] rd_q;
    logic [W-1:0]  data_q;
    logic [W-1:0]  target_q;
    logic [3:0]    flags_q;
    logic [15:0]   retired_q;

    logic drain;
    logic accept;
    logic op_writes;
    logic op_flags;
    logic cond_true;

    // Opcode classes: writing ops also update flags; CMP updates flags only.
    always_comb begin
        op_writes = 1'b0;
        op_flags  = 1'b0;
        case (ex_opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110,
            4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                op_writes = 1'b1;
                op_flags  = 1'b1;
            end
            4'b0101: op_flags = 1'b1;
            default: ;
        endcase
    end

    // Branches resolve against the flags held before this edge.
    always_comb begin
        cond_true = 1'b0;
        case (ex_cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_q[2];
            3'b010:  cond_true = !flags_q[2];
            3'b011:  cond_true = flags_q[3] ^ flags_q[0];
            3'b100:  cond_true = flags_q[2] | (flags_q[3] ^ flags_q[0]);
            3'b101:  cond_true = flags_q[1];
            3'b110:  cond_true = !flags_q[1];
            default: cond_true = 1'b0;
        endcase
    end

    assign drain    = valid_q && (!we_q || rf_ready);
    assign ex_ready = rst_n && (!valid_q || drain);
    assign accept   = ex_valid && ex_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            is_br_q  <= 1'b0;
            taken_q  <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            target_q <= '0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            we_q     <= !ex_is_br && op_writes;
            is_br_q  <= ex_is_br;
            taken_q  <= ex_is_br && cond_true;
            rd_q     <= ex_rd;
            data_q   <= ex_result;
            target_q <= ex_target;
        end else if (drain) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            is_br_q <= 1'b0;
            taken_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (accept && !ex_is_br && op_flags) begin
            flags_q <= {ex_s, ex_z, ex_c, ex_v};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 16'd0;
        end else if (drain) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign rf_we     = valid_q && we_q;
    assign rf_waddr  = rd_q;
    assign rf_wdata  = data_q;
    assign fwd_valid = rf_we;
    assign fwd_rd    = rd_q;
    assign fwd_data  = data_q;
    assign flags     = flags_q;
    assign br_taken  = valid_q && is_br_q && taken_q;
    assign br_target = br_taken ? target_q : '0;
    assign retired   = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus random traffic,
// all compared every cycle against a queue-based model of the writeback stage.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_is_br = 1'b0;
    logic [3:0]  ex_opcode = 4'd0;
    logic [2:0]  ex_rd = 3'd0;
    logic [15:0] ex_result = 16'd0;
    logic        ex_s = 1'b0, ex_z = 1'b0, ex_c = 1'b0, ex_v = 1'b0;
    logic [2:0]  ex_cond = 3'd0;
    logic [15:0] ex_target = 16'd0;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_ready = 1'b0;
    logic        fwd_valid;
    logic [2:0]  fwd_rd;
    logic [15:0] fwd_data;
    logic [3:0]  flags;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] retired;

    alu_writeback #(.W(16), .RA(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_br(ex_is_br),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_result(ex_result),
        .ex_s(ex_s), .ex_z(ex_z), .ex_c(ex_c), .ex_v(ex_v),
        .ex_cond(ex_cond), .ex_target(ex_target),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flags(flags), .br_taken(br_taken), .br_target(br_target), .retired(retired)
    );

    always #5 clk = ~clk;

    // Opcode sets written as bitmaps: bit k set means opcode k belongs to the set.
    localparam logic [15:0] WRITE_SET = 16'h0F5F;
    localparam logic [15:0] FLAG_SET  = 16'h0F7F;

    typedef struct {
        bit          writes;
        bit          is_br;
        bit          taken;
        logic [2:0]  rd;
        logic [15:0] data;
        logic [15:0] target;
    } entry_t;

    entry_t      pend[$];
    logic [3:0]  m_flags;
    logic [15:0] m_retired;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit branch_ok(input logic [2:0] cond, input logic [3:0] f);
        bit s, z, c, v;
        {s, z, c, v} = f;
        case (cond)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return s != v;
            3'd4: return z || (s != v);
            3'd5: return c;
            3'd6: return !c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_ready();
        return rst_n && (pend.size() == 0 || !pend[0].writes || rf_ready);
    endfunction

    task automatic modelReset();
        pend.delete();
        m_flags   = 4'd0;
        m_retired = 16'd0;
    endtask

    // Advances the model across one rising edge using the inputs held before it.
    task automatic modelStep();
        bit     acc;
        entry_t e;
        if (!rst_n) begin
            modelReset();
            return;
        end
        acc = ex_valid && model_ready();
        if (pend.size() > 0 && (!pend[0].writes || rf_ready)) begin
            void'(pend.pop_front());
            m_retired = m_retired + 16'd1;
        end
        if (acc) begin
            e.is_br  = ex_is_br;
            e.taken  = ex_is_br && branch_ok(ex_cond, m_flags);
            e.writes = !ex_is_br && WRITE_SET[ex_opcode];
            e.rd     = ex_rd;
            e.data   = ex_result;
            e.target = ex_target;
            if (!ex_is_br && FLAG_SET[ex_opcode]) m_flags = {ex_s, ex_z, ex_c, ex_v};
            pend.push_back(e);
        end
    endtask

    task automatic checkOutput();
        bit          exp_we, exp_br;
        logic [15:0] exp_tgt;
        exp_we  = pend.size() > 0 && pend[0].writes;
        exp_br  = pend.size() > 0 && pend[0].is_br && pend[0].taken;
        exp_tgt = exp_br ? pend[0].target : 16'd0;
        chk("ex_ready", ex_ready, model_ready());
        chk("rf_we", rf_we, exp_we);
        chk("fwd_valid", fwd_valid, exp_we);
        if (exp_we) begin
            chk("rf_waddr", rf_waddr, pend[0].rd);
            chk("rf_wdata", rf_wdata, pend[0].data);
            chk("fwd_rd", fwd_rd, pend[0].rd);
            chk("fwd_data", fwd_data, pend[0].data);
        end
        chk("flags", flags, m_flags);
        chk("br_taken", br_taken, exp_br);
        chk("br_target", br_target, exp_tgt);
        chk("retired", retired, m_retired);
    endtask

    task automatic applyStimulus(input bit v, input bit br, input logic [3:0] op,
                                 input logic [2:0] rd, input logic [15:0] res,
                                 input logic [3:0] f, input logic [2:0] cond,
                                 input logic [15:0] tgt, input bit rdy);
        ex_valid  = v;
        ex_is_br  = br;
        ex_opcode = op;
        ex_rd     = rd;
        ex_result = res;
        {ex_s, ex_z, ex_c, ex_v} = f;
        ex_cond   = cond;
        ex_target = tgt;
        rf_ready  = rdy;
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle();
        #1 checkOutput();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 1'b0, 4'd0, 3'd0, 16'd0, 4'd0, 3'd0, 16'd0, rdy);
    endtask

    initial begin
        logic [15:0] r0;
        logic [3:0]  f0;
        int          budget;

        modelReset();
        @(negedge clk);
        cycle();
        cycle();
        chk("reset_rf_we", rf_we, 1'b0);
        chk("reset_ex_ready", ex_ready, 1'b0);
        chk("reset_flags", flags, 4'd0);
        chk("reset_retired", retired, 16'd0);
        rst_n = 1'b1;
        #1 chk("release_ex_ready", ex_ready, 1'b1);
        idle(1'b1);
        cycle();

        // ADD result 0, Z=1 C=1, rd=3.
        applyStimulus(1'b1, 1'b0, 4'b0000, 3'd3, 16'h0000, 4'b0110, 3'd0, 16'd0, 1'b1);
        cycle();
        chk("add_rf_we", rf_we, 1'b1);
        chk("add_waddr", rf_waddr, 3'd3);
        chk("add_wdata", rf_wdata, 16'h0000);
        chk("add_fwd_valid", fwd_valid, 1'b1);
        idle(1'b1);
        cycle();
        chk("add_flags", flags, 4'b0110);
        chk("add_retired", retired, 16'd1);

        // CMP with Z=1, then branches on Z and !Z.
        applyStimulus(1'b1, 1'b0, 4'b0101, 3'd1, 16'h0000, 4'b0100, 3'd0, 16'd0, 1'b1);
        cycle();
        chk("cmp_no_write", rf_we, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0000, 3'd0, 16'd0, 4'b0000, 3'b001, 16'h0040, 1'b1);
        cycle();
        chk("beq_taken", br_taken, 1'b1);
        chk("beq_target", br_target, 16'h0040);
        chk("beq_no_write", rf_we, 1'b0);
        idle(1'b1);
        cycle();
        chk("beq_pulse_end", br_taken, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0000, 3'd0, 16'd0, 4'b0000, 3'b010, 16'h0040, 1'b1);
        cycle();
        chk("bne_not_taken", br_taken, 1'b0);
        chk("bne_flags_kept", flags, 4'b0100);
        idle(1'b1);
        cycle();

        // SUB to rd=5 stalled by the register file for 3 cycles.
        r0 = m_retired;
        applyStimulus(1'b1, 1'b0, 4'b0001, 3'd5, 16'h1234, 4'b0000, 3'd0, 16'd0, 1'b1);
        cycle();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) applyStimulus(1'b1, 1'b0, 4'b0111, 3'd6, 16'hAAAA, 4'b1111, 3'd0, 16'd0, 1'b0);
            else       idle(1'b1);
            #1;
            chk("bp_rf_we", rf_we, 1'b1);
            chk("bp_waddr", rf_waddr, 3'd5);
            chk("bp_wdata", rf_wdata, 16'h1234);
            chk("bp_ex_ready", ex_ready, (i == 3));
            chk("bp_retired_hold", retired, r0);
            cycle();
        end
        chk("bp_retired_inc", retired, r0 + 16'd1);

        // Reserved opcodes: staged and retired, no write, no flag change.
        r0 = m_retired;
        f0 = flags;
        applyStimulus(1'b1, 1'b0, 4'b0111, 3'd2, 16'hFFFF, ~f0, 3'd0, 16'd0, 1'b1);
        cycle();
        chk("rsv7_no_write", rf_we, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b1111, 3'd2, 16'hFFFF, ~f0, 3'd0, 16'd0, 1'b1);
        cycle();
        chk("rsvF_no_write", rf_we, 1'b0);
        idle(1'b1);
        cycle();
        chk("rsv_flags", flags, f0);
        chk("rsv_retired", retired, r0 + 16'd2);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                          4'($urandom), 3'($urandom), 16'($urandom), 4'($urandom),
                          3'($urandom), 16'($urandom), $urandom_range(0, 9) < 7);
            cycle();
        end

        // Counter wrap: fresh reset, then a steady stream of non-writing ops.
        rst_n = 1'b0;
        modelReset();
        idle(1'b1);
        cycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'b0111, 3'd0, 16'd0, 4'd0, 3'd0, 16'd0, 1'b1);
        budget = 70000;
        while (m_retired != 16'hFFFF && budget > 0) begin
            cycle();
            budget--;
        end
        chk("wrap_budget", (budget > 0), 1'b1);
        chk("wrap_preload", retired, 16'hFFFF);
        idle(1'b1);
        cycle();
        chk("wrap_zero", retired, 16'h0000);

        // Reset asserted while a write is held.
        applyStimulus(1'b1, 1'b0, 4'b0000, 3'd2, 16'hBEEF, 4'b1000, 3'd0, 16'd0, 1'b1);
        cycle();
        idle(1'b0);
        #1 chk("mid_rf_we_before", rf_we, 1'b1);
        rst_n = 1'b0;
        modelReset();
        #1;
        chk("mid_rf_we_async", rf_we, 1'b0);
        chk("mid_fwd_valid", fwd_valid, 1'b0);
        chk("mid_ex_ready", ex_ready, 1'b0);
        chk("mid_flags", flags, 4'd0);
        chk("mid_retired", retired, 16'd0);
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        idle(1'b1);
        #1 chk("mid_release_ready", ex_ready, 1'b1);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the 16-bit ALU. Registers each ALU result with its destination register, drives the register-file write port under a valid/ready handshake, and keeps the architectural condition-code register (S, Z, C, V) from the ALU flag outputs. It also resolves conditional branches against the held flags, exposes the pending result for forwarding to the operand stage, and counts retired instructions.

## Interface
- `W`, default 16: datapath width; matches the ALU.
- `RA`, default 3: register address width (8 registers).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `ex_valid` in 1: the execute stage presents an instruction.
- `ex_ready` out 1: the stage accepts the instruction this cycle.
- `ex_is_br` in 1: 1 = conditional branch, 0 = ALU operation.
- `ex_opcode` in 4: ALU opcode, the same encoding the ALU uses.
- `ex_rd` in RA: destination register.
- `ex_result` in W: ALU `alu_out`.
- `ex_s`, `ex_z`, `ex_c`, `ex_v` in 1 each: ALU flags.
- `ex_cond` in 3: branch condition code.
- `ex_target` in W: branch target address.
- `rf_we` out 1: register-file write request.
- `rf_waddr` out RA: write address.
- `rf_wdata` out W: write data.
- `rf_ready` in 1: the register file accepts the write this cycle.
- `fwd_valid` out 1: a staged write is pending.
- `fwd_rd` out RA: destination register of the pending write.
- `fwd_data` out W: data of the pending write.
- `flags` out 4: {S,Z,C,V} condition-code register.
- `br_taken` out 1: one-cycle pulse when a branch is taken.
- `br_target` out W: target address, valid while `br_taken` is high.
- `retired` out 16: count of retired instructions.

## Operation
- **Stage register.** Holds one entry: `valid`, `we`, `rd`, `data`, `is_br`, `taken`, `target`.
- **Accept.** An instruction is accepted when `ex_valid && ex_ready`.
- **Drain.** The entry drains when `valid && (!we || rf_ready)`.
- **Ready.** `ex_ready = !valid || drain`. Accept and drain in the same cycle are allowed; the new entry replaces the old one.
- **ALU op classes.**
  - Write-back plus flag update: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0110 MOV, 1000 through 1011 (shifts and rotate).
  - Flags only, `we=0`: 0101 CMP.
  - No write and no flag update: 0111 and 1100 through 1111. These are still staged and retired.
- **Flag register.** Loaded from `ex_s/z/c/v` on the accept edge of a flag-updating op.
- **Branch evaluation.** A branch is evaluated at accept against the current `flags` register, i.e. the value before this edge.
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 S^V
  - 100 Z|(S^V)
  - 101 C
  - 110 !C
  - 111 never
- **Branch staging.** A branch is staged with `we=0` and `taken` and `target` recorded. Branches never modify the flags.
- **Outputs from the stage register.**
  - `rf_we = valid && we`
  - `rf_waddr = rd`, `rf_wdata = data`
  - `fwd_valid = rf_we`, `fwd_rd = rd`, `fwd_data = data`
  - `br_taken = valid && is_br && taken`
  - `br_target = target` when `br_taken`, else 0.
- **Write hold.** While `rf_we && !rf_ready`, `rf_waddr` and `rf_wdata` stay stable and `ex_ready` is 0.
- **Retire counter.** `retired` increments by 1 on every drain and wraps from 0xFFFF to 0x0000.
- **No internal flush.** Upstream squashes wrong-path work on `br_taken`; this stage itself flushes nothing.

## Timing
- **Reset.** While `rst_n` is low, every output is 0: `ex_ready=0`, `rf_we=0`, `fwd_valid=0`, `flags=0`, `br_taken=0`, `br_target=0`, `retired=0`. Stage `valid` is 0.
- **Reset release.** `ex_ready` becomes 1 combinationally from the cleared stage.
- **Reset mid-operation.** A pending write is dropped. `rf_we` falls asynchronously with reset assertion.
- **Latency.** Accept on edge N puts `rf_we` (or `br_taken`) high in cycle N+1.
  - Minimum occupancy is one cycle, so throughput is 1 per cycle while `rf_ready=1`.
  - Non-writing entries always drain in one cycle, so `br_taken` is exactly one cycle wide.
- **Flag visibility.** Flags written on edge N are visible at `flags` in cycle N+1.
  - A branch accepted on edge N+1 sees them.
  - A branch accepted on the same edge N as a CMP is impossible, because only one instruction is accepted per cycle.
- **Back-pressure.** `rf_ready=0` for k cycles extends the entry by k cycles, holds `retired`, and blocks further accepts (`ex_ready=0`).

## Test plan
- **Reset.** Reset, then release → all outputs 0 and `ex_ready=1`.
- **ADD write and flags.** ADD with result 0x0000, Z=1, C=1, rd=3 → next cycle `rf_we=1`, `rf_waddr=3`, `rf_wdata=0x0000`, `fwd_valid=1`; the cycle after, `flags=4'b0110` and `retired=1`.
- **CMP then branch.** CMP with Z=1, then a branch with cond=001 and target 0x0040 → no `rf_we`; `br_taken` pulses for one cycle with `br_target=0x0040`. Repeat with cond=010 → `br_taken` stays 0.
- **Back-pressure.** Hold `rf_ready=0` for 3 cycles during a SUB to rd=5, data 0x1234 → `rf_we`, `rf_waddr`, and `rf_wdata` are stable for 4 cycles; `ex_ready=0` for 3 cycles; `retired` increments once, when `rf_ready` returns.
- **Reserved opcodes.** Opcodes 0111 and 1111 → no write and `flags` unchanged; `retired` increments once for each.
- **Counter wrap and reset mid-write.** Preload with 65535 retirements, then one more → `retired=0x0000`. Assert `rst_n` low while `rf_we=1` → `rf_we` drops immediately, with no clock edge needed.
